resta_result_reg: RTL and testbench

// - Output register stage directly downstream of the M-bit subtractor (resta).
// - Captures result R and flags C/N/V/Z into a 2-entry skid buffer.
// - Uses a valid/ready handshake so later consumers (status/flag register, display) can stall.
// - Keeps a saturating count of results captured with V=1, used for diagnostics.

---
 rtl/resta_result_reg.sv | 118 +++++++++++
 tb/tb_resta_result_reg.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/resta_result_reg.sv
// Output register stage behind the subtractor: a 2-entry skid buffer with a
// valid/ready handshake and a saturating count of overflow results.
module resta_result_reg #(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     R_in,
  input  logic             C_in,
  input  logic             N_in,
  input  logic             V_in,
  input  logic             Z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     R_out,
  output logic [3:0]       flags_out,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int unsigned FLAG_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              push, pop;
  logic              ld_head_in, ld_head_tail, ld_tail;
  logic [FLAG_W-1:0] flags_in;
  logic [M-1:0]      tail_r;
  logic [FLAG_W-1:0] tail_f;

  assign flags_in  = {N_in, Z_in, C_in, V_in};

  // Handshake status comes only from the state register, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt  = ONE;
          ld_head_in = 1'b1;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_nxt = FULL;
            ld_tail   = 1'b1;
          end
          2'b01: state_nxt = EMPTY;
          2'b11: ld_head_in = 1'b1;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          state_nxt    = ONE;
          ld_head_tail = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Head entry drives the outputs directly and holds its value when the buffer empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R_out     <= '0;
      flags_out <= '0;
    end else if (ld_head_in) begin
      R_out     <= R_in;
      flags_out <= flags_in;
    end else if (ld_head_tail) begin
      R_out     <= tail_r;
      flags_out <= tail_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tail_r <= '0;
      tail_f <= '0;
    end else if (ld_tail) begin
      tail_r <= R_in;
      tail_f <= flags_in;
    end
  end

  // Clear wins over a simultaneous overflow push; the count sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      ovf_cnt <= '0;
    else if (clr_cnt)                                ovf_cnt <= '0;
    else if (push && V_in && (ovf_cnt != CNT_MAX))   ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_resta_result_reg.sv
// Bench for resta_result_reg: directed scenarios plus random traffic, checked
// against a queue-based model of the skid buffer and overflow counter.
module tb_resta_result_reg;

  localparam int unsigned M     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [M-1:0]     R_in;
  logic             C_in, N_in, V_in, Z_in;
  logic             out_valid, out_ready;
  logic [M-1:0]     R_out;
  logic [3:0]       flags_out;
  logic             clr_cnt;
  logic [CNT_W-1:0] ovf_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Model: queue of {R, N, Z, C, V}, last visible head, overflow count
  logic [7:0] mq[$];
  logic [7:0] last_head;
  int         mcnt;

  always #5 clk = ~clk;

  resta_result_reg #(.M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .R_in(R_in), .C_in(C_in), .N_in(N_in), .V_in(V_in), .Z_in(Z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_out(R_out), .flags_out(flags_out),
    .clr_cnt(clr_cnt), .ovf_cnt(ovf_cnt)
  );

  function automatic logic [17:0] dut_obs();
    return {out_valid, in_ready, R_out, flags_out, ovf_cnt};
  endfunction

  function automatic logic [17:0] model_obs();
    logic [7:0] h;
    h = (mq.size() > 0) ? mq[0] : last_head;
    return {mq.size() != 0, mq.size() < 2, h, 8'(mcnt)};
  endfunction

  task automatic model_reset();
    mq.delete();
    last_head = 8'h00;
    mcnt      = 0;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] f);
    in_valid = v;
    R_in     = r;
    {N_in, Z_in, C_in, V_in} = f;
  endtask

  // Advance one clock, updating the model from the inputs seen at that edge.
  task automatic tick();
    logic push_m, pop_m;
    logic [7:0] e;
    e      = {R_in, N_in, Z_in, C_in, V_in};
    push_m = in_valid && (mq.size() < 2);
    pop_m  = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (pop_m) void'(mq.pop_front());
    if (push_m) mq.push_back(e);
    if (mq.size() > 0) last_head = mq[0];
    if (clr_cnt) mcnt = 0;
    else if (push_m && V_in && mcnt < 255) mcnt++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0);
    out_ready = 1'b0;
    clr_cnt   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_obs() !== 18'b01_0000_0000_00000000) begin
      miscompares++;
      $display("FAIL reset: got %b exp %b", dut_obs(), 18'b01_0000_0000_00000000);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (dut_obs() !== model_obs()) begin
      miscompares++;
      $display("FAIL reset_idle: got %h exp %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 4'b0010, 4'b0010);
    tick();
    vectors++;
    if (dut_obs() !== model_obs() || R_out !== 4'b0010 || flags_out !== 4'b0010 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out: got %h exp %h", dut_obs(), model_obs());
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (dut_obs() !== model_obs() || out_valid !== 1'b0 || R_out !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_pop: got %h exp %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got[$];
    logic [3:0] exp_seq[3];
    logic       sent;
    exp_seq = '{4'b0010, 4'b1110, 4'b0000};
    out_ready = 1'b0;
    drive(1'b1, 4'b0010, 4'h0);
    tick();
    drive(1'b1, 4'b1110, 4'h0);
    tick();
    vectors++;
    if (dut_obs() !== model_obs() || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got %h exp %h", dut_obs(), model_obs());
    end
    drive(1'b1, 4'b0000, 4'h0);
    repeat (2) begin
      tick();
      vectors++;
      if (dut_obs() !== model_obs() || in_ready !== 1'b0 || R_out !== 4'b0010) begin
        miscompares++;
        $display("FAIL bp_stall: got %h exp %h", dut_obs(), model_obs());
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) got.push_back(R_out);
      sent = in_valid && in_ready;
      tick();
      if (sent) in_valid = 1'b0;
      vectors++;
      if (dut_obs() !== model_obs()) begin
        miscompares++;
        $display("FAIL bp_drain: cycle %0d got %h exp %h", i, dut_obs(), model_obs());
      end
    end
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL bp_count: got %0d exp 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL bp_order: idx %0d got %b exp %b", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int v = 1; v <= 7; v++) begin
      drive(1'b1, 4'(v), 4'($urandom_range(0, 15)));
      tick();
      vectors++;
      if (dut_obs() !== model_obs() || out_valid !== 1'b1 || in_ready !== 1'b1 || R_out !== 4'(v)) begin
        miscompares++;
        $display("FAIL stream: v %0d got %h exp %h", v, dut_obs(), model_obs());
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (dut_obs() !== model_obs()) begin
      miscompares++;
      $display("FAIL stream_drain: got %h exp %h", dut_obs(), model_obs());
    end
  endtask

  task automatic test_ovf_cnt();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), {3'($urandom_range(0, 7)), 1'b1});
      tick();
      vectors++;
      if (dut_obs() !== model_obs()) begin
        miscompares++;
        $display("FAIL ovf_step: i %0d got %h exp %h", i, dut_obs(), model_obs());
      end
    end
    vectors++;
    if (ovf_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL ovf_sat: got %0d exp 255", ovf_cnt);
    end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    vectors++;
    if (ovf_cnt !== 8'd0 || dut_obs() !== model_obs()) begin
      miscompares++;
      $display("FAIL ovf_clr: got %h exp %h", dut_obs(), model_obs());
    end
    tick();
    vectors++;
    if (ovf_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL ovf_after_clr: got %0d exp 1", ovf_cnt);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    repeat (2) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
    end
    vectors++;
    if (in_ready !== 1'b0 || dut_obs() !== model_obs()) begin
      miscompares++;
      $display("FAIL mid_full: got %h exp %h", dut_obs(), model_obs());
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (dut_obs() !== model_obs() || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_async: got %h exp %h", dut_obs(), model_obs());
    end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      vectors++;
      if (dut_obs() !== model_obs() || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_after: got %h exp %h", dut_obs(), model_obs());
      end
    end
  endtask

  task automatic test_random();
    logic accepted;
    accepted = 1'b1;
    for (int i = 0; i < 500; i++) begin
      // Upstream holds an unaccepted offer unchanged until it is taken.
      if (!in_valid || accepted)
        drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 2) != 0);
      clr_cnt   = 1'($urandom_range(0, 31) == 0);
      accepted  = in_valid && in_ready;
      tick();
      vectors++;
      if (dut_obs() !== model_obs()) begin
        miscompares++;
        $display("FAIL random: i %0d got %h exp %h", i, dut_obs(), model_obs());
      end
    end
    clr_cnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_ovf_cnt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
